riscv_alu_arbiter: RTL
======================

Name: riscv_alu_arbiter

Overview:
- Shares one riscv_alu instance between two requesters: r0 is the EX-stage integer path, r1 is the address-generation / auxiliary unit.
- Arbitrates per cycle and drives the ALU operands and control from the winner.
- Captures the combinational ALU result into a single-entry response register and returns it on one tagged response channel with valid/ready flow control.

Parameters:
- P_TAG_W, 4, width of the requester-supplied transaction tag echoed with the response.
- P_FIXED_PRIO, 0, 0 = round-robin between r0/r1; 1 = r0 always wins on contention.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_r0_valid  input  1  r0 request valid.
- o_r0_ready  output  1  r0 request accepted this cycle.
- i_r0_a  input  `XLEN  r0 operand A.
- i_r0_b  input  `XLEN  r0 operand B.
- i_r0_ctrl  input  5  r0 ALU control code (`ALU_CTRL_*).
- i_r0_tag  input  P_TAG_W  r0 tag.
- i_r1_valid, o_r1_ready, i_r1_a, i_r1_b, i_r1_ctrl, i_r1_tag: same as r0, for r1.
- o_alu_a  output  `XLEN  ALU operand A.
- o_alu_b  output  `XLEN  ALU operand B.
- o_alu_ctrl  output  5  ALU control.
- i_alu_result  input  `XLEN  ALU result (combinational from o_alu_*).
- i_alu_zero  input  1  ALU zero flag.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_id  output  1  requester of the response (0 = r0, 1 = r1).
- o_rsp_result  output  `XLEN  registered ALU result.
- o_rsp_zero  output  1  registered zero flag.
- o_rsp_tag  output  P_TAG_W  echoed tag.

Behaviour:
- Clocking and reset: single clock domain; i_rst is synchronous and active-high.
- Reset values:
  - o_rsp_valid = 0; o_rsp_id, o_rsp_result, o_rsp_zero, o_rsp_tag = 0.
  - Round-robin pointer last_grant = 1, so r0 wins the first contention.
- Slot free: slot_free = !o_rsp_valid | i_rsp_ready. The response register is drained and refilled in the same cycle, giving 1 op/cycle sustained throughput.
- Grant, combinational:
  - No grant while i_rst = 1 or slot_free = 0.
  - Otherwise, with only one valid requester, grant it.
  - With both valid: P_FIXED_PRIO = 1 grants r0; P_FIXED_PRIO = 0 grants the requester != last_grant.
- Ready: o_rN_ready = grant_N. At most one ready per cycle.
- Requester rules:
  - Valid must not depend on ready.
  - Once valid is raised, payload is held stable until ready.
  - Valid is not withdrawn before acceptance.
- ALU drive:
  - On a grant, o_alu_a/b/ctrl = winner's a/b/ctrl.
  - With no grant, o_alu_a = 0, o_alu_b = 0, o_alu_ctrl = `ALU_CTRL_ADD (keeps ALU inputs quiet).
- Capture, on the posedge of a grant cycle:
  - o_rsp_result <= i_alu_result; o_rsp_zero <= i_alu_zero.
  - o_rsp_tag <= winner tag; o_rsp_id <= winner index; o_rsp_valid <= 1.
  - last_grant <= winner index, updated only on a contended or uncontended grant.
- Latency: a request accepted in cycle N is presented with o_rsp_valid = 1 in cycle N+1.
- Drain: if o_rsp_valid & i_rsp_ready and there is no new grant, o_rsp_valid <= 0. Data fields hold their last value.
- Backpressure: while o_rsp_valid = 1 and i_rsp_ready = 0, o_rsp_* hold stable and both readies stay 0.
- Reset mid-operation: a pending response is discarded; o_rsp_valid = 0 the cycle after i_rst is sampled high, and the pointer returns to 1.
- Operand width rules: none added by this block; operands are passed through unmodified. Shift amount truncation (b[4:0]) and signedness are the ALU's responsibility.

Optional Feature:
- Macro: RISCV_ALU_ARB_STATS_EN.
- When defined, adds three 16-bit outputs:
  - o_stat_r0_grants: count of r0 grants.
  - o_stat_r1_grants: count of r1 grants.
  - o_stat_conflicts: count of cycles with both valid and slot_free.
  - Each counter saturates at 16'hFFFF, is cleared by i_rst, and increments on the posedge that captures the event.
- When undefined, these ports and counters do not exist and the block's behaviour is otherwise identical.

Test Plan:
- Single requester, no contention:
  - Stimulus: r0 valid only, a=5, b=3, ctrl=ADD, tag=2, i_rsp_ready=1.
  - Required: o_r0_ready=1 in cycle N; cycle N+1 gives o_rsp_valid=1, result=8, zero=0, id=0, tag=2.
- Round-robin contention:
  - Stimulus: r0 and r1 held valid for 4 cycles, P_FIXED_PRIO=0, i_rsp_ready=1.
  - Required: grant order r0, r1, r0, r1; o_rsp_id sequence 0, 1, 0, 1 one cycle later.
- Backpressure:
  - Stimulus: r1 request a=32'hFFFF_FFFF, b=1, ctrl=ADD accepted; i_rsp_ready=0 for 3 cycles.
  - Required: o_rsp_valid=1, result=0, zero=1 held stable for 3 cycles, both readies 0.
  - Then: i_rsp_ready=1 with r0 valid gives same-cycle drain plus a new grant, and o_rsp_valid stays 1 with the new result next cycle.
- Fixed priority:
  - Stimulus: P_FIXED_PRIO=1, both valid for 3 cycles.
  - Required: r0 granted every cycle, o_r1_ready=0 throughout.
- Reset mid-operation:
  - Stimulus: i_rst=1 for one cycle while o_rsp_valid=1 and both requesters valid.
  - Required: no ready during reset; next cycle o_rsp_valid=0 and o_rsp_* = 0; first post-reset contention grants r0.
- Stats (with RISCV_ALU_ARB_STATS_EN):
  - Stimulus: the round-robin scenario above.
  - Required: o_stat_r0_grants=2, o_stat_r1_grants=2, o_stat_conflicts=4.

Source files
------------

// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter: two requesters share one ALU; optional grant/conflict counters with RISCV_ALU_ARB_STATS_EN.
// Latency: accepted in cycle N, response valid in N+1. Backpressure: a held response blocks all grants until drained.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_CTRL_ADD
`define ALU_CTRL_ADD 5'b00000
`endif

module riscv_alu_arbiter #(
  parameter int P_TAG_W      = 4,
  parameter int P_FIXED_PRIO = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_r0_valid,
  output logic               o_r0_ready,
  input  logic [`XLEN-1:0]   i_r0_a,
  input  logic [`XLEN-1:0]   i_r0_b,
  input  logic [4:0]         i_r0_ctrl,
  input  logic [P_TAG_W-1:0] i_r0_tag,
  input  logic               i_r1_valid,
  output logic               o_r1_ready,
  input  logic [`XLEN-1:0]   i_r1_a,
  input  logic [`XLEN-1:0]   i_r1_b,
  input  logic [4:0]         i_r1_ctrl,
  input  logic [P_TAG_W-1:0] i_r1_tag,
  output logic [`XLEN-1:0]   o_alu_a,
  output logic [`XLEN-1:0]   o_alu_b,
  output logic [4:0]         o_alu_ctrl,
  input  logic [`XLEN-1:0]   i_alu_result,
  input  logic               i_alu_zero,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [`XLEN-1:0]   o_rsp_result,
  output logic               o_rsp_zero,
  output logic [P_TAG_W-1:0] o_rsp_tag
`ifdef RISCV_ALU_ARB_STATS_EN
  ,
  output logic [15:0]        o_stat_r0_grants,
  output logic [15:0]        o_stat_r1_grants,
  output logic [15:0]        o_stat_conflicts
`endif
);

  logic               slot_free, both_vld, grant0, grant1, any_grant;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               last_grant_q, last_grant_d;
  logic [`XLEN-1:0]   rsp_result_q, rsp_result_d;
  logic [P_TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  // The response slot can be drained and refilled in the same cycle.
  assign slot_free = ~rsp_valid_q | i_rsp_ready;
  assign both_vld  = i_r0_valid & i_r1_valid;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!i_rst && slot_free) begin
      if (both_vld) begin
        if ((P_FIXED_PRIO != 0) || last_grant_q) grant0 = 1'b1;
        else                                     grant1 = 1'b1;
      end else begin
        grant0 = i_r0_valid;
        grant1 = i_r1_valid;
      end
    end
  end

  assign any_grant  = grant0 | grant1;
  assign o_r0_ready = grant0;
  assign o_r1_ready = grant1;

  always_comb begin
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = `ALU_CTRL_ADD;
    if (grant0) begin
      o_alu_a    = i_r0_a;
      o_alu_b    = i_r0_b;
      o_alu_ctrl = i_r0_ctrl;
    end else if (grant1) begin
      o_alu_a    = i_r1_a;
      o_alu_b    = i_r1_b;
      o_alu_ctrl = i_r1_ctrl;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    last_grant_d = last_grant_q;
    if (any_grant) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_zero_d   = i_alu_zero;
      rsp_result_d = i_alu_result;
      rsp_tag_d    = grant1 ? i_r1_tag : i_r0_tag;
      last_grant_d = grant1;
    end else if (i_rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_zero   = rsp_zero_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_tag    = rsp_tag_q;

`ifdef RISCV_ALU_ARB_STATS_EN
  logic [15:0] stat_r0_q, stat_r1_q, stat_cf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_r0_q <= '0;
      stat_r1_q <= '0;
      stat_cf_q <= '0;
    end else begin
      if (grant0 && (stat_r0_q != 16'hFFFF)) stat_r0_q <= stat_r0_q + 16'd1;
      if (grant1 && (stat_r1_q != 16'hFFFF)) stat_r1_q <= stat_r1_q + 16'd1;
      if (both_vld && slot_free && (stat_cf_q != 16'hFFFF)) stat_cf_q <= stat_cf_q + 16'd1;
    end
  end

  assign o_stat_r0_grants = stat_r0_q;
  assign o_stat_r1_grants = stat_r1_q;
  assign o_stat_conflicts = stat_cf_q;
`endif

endmodule
